simd_issue_ctrl: RTL and testbench

- Instruction issue controller placed in front of the 4-stage SIMD datapath (IF, ID, EX, WB), which has no forwarding and no stall input.
- Buffers incoming 12-bit instructions in a small FIFO and issues exactly one word per clock.
- When a register read-after-write hazard exists, or the FIFO is empty, it issues a bubble instead.
- Reports write-back retirement and hazard statistics to the testbench or host.

---
 rtl/simd_pkg.sv | 91 +++++++++
 rtl/simd_instr_fifo.sv | 47 ++++
 rtl/simd_issue_ctrl.sv | 118 +++++++++++
 tb/tb_simd_issue_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types, opcodes and field helpers for the SIMD issue controller.
// Instruction layout: [11:8] op, [7:6] bw, [5:4] fc, [3:2] fb, [1:0] fa.
package simd_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_MAC = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam logic [11:0] BUBBLE_INSTR = 12'hFFF;

  typedef struct packed {
    logic [2:0]      v;
    logic [2:0][3:0] r;
  } src_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] dest;
  } sb_ent_t;

  function automatic logic [3:0] op_f(logic [11:0] i);
    return i[11:8];
  endfunction

  function automatic logic [1:0] bw_f(logic [11:0] i);
    return i[7:6];
  endfunction

  function automatic logic [1:0] fc_f(logic [11:0] i);
    return i[5:4];
  endfunction

  function automatic logic [1:0] fb_f(logic [11:0] i);
    return i[3:2];
  endfunction

  function automatic logic [1:0] fa_f(logic [11:0] i);
    return i[1:0];
  endfunction

  function automatic logic [3:0] dest_f(logic [11:0] i);
    return {bw_f(i), fc_f(i)};
  endfunction

  function automatic src_t src_regs(logic [11:0] i);
    src_t       s;
    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rd;
    logic [3:0] rl;
    s  = '0;
    op = op_f(i);
    ra = {bw_f(i), fa_f(i)};
    rb = {bw_f(i), fb_f(i)};
    rd = dest_f(i);
    rl = {fb_f(i), fa_f(i)};
    unique case (1'b1)
      op inside {OP_ADD, OP_SUB, OP_MUL}: begin
        s.v = 3'b011;
        s.r = {4'h0, rb, ra};
      end
      op == OP_MAC: begin
        s.v = 3'b111;
        s.r = {rd, rb, ra};
      end
      op inside {OP_SHL, OP_SHR}: begin
        s.v = 3'b001;
        s.r = {4'h0, 4'h0, ra};
      end
      op inside {OP_AND, OP_OR, OP_XOR}: begin
        s.v = 3'b101;
        s.r = {rd, 4'h0, rl};
      end
      op == OP_NOT: begin
        s.v = 3'b001;
        s.r = {4'h0, 4'h0, rl};
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/simd_instr_fifo.sv
// Synchronous instruction FIFO with occupancy count.
// A push and a pop on the same edge are both honoured.
module simd_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/simd_issue_ctrl.sv
// Issue controller for the 4-stage SIMD datapath: one word per clock,
// bubbles on empty FIFO or RAW hazard, plus retire and stall reporting.
module simd_issue_ctrl
  import simd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [11:0]      in_instr,
  output logic             in_ready,
  output logic [11:0]      issue_instr,
  output logic             issue_real,
  output logic             retire_valid,
  output logic [3:0]       retire_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       fifo_level,
  output logic             busy
);

  localparam int SB_N  = PIPE_LAT - 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [11:0]      head;
  logic [LVL_W-1:0] lvl;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             hazard;
  logic             sb_any;
  src_t             src;

  sb_ent_t [SB_N-1:0] sb_q;
  sb_ent_t            ret_q;

  logic [11:0]      issue_instr_q;
  logic             issue_real_q;
  logic             retire_valid_q;
  logic [3:0]       retire_dest_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  simd_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (12),
    .CW    (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_instr),
    .rdata_o (head),
    .count_o (lvl),
    .full_o  (full),
    .empty_o (empty)
  );

  assign src = src_regs(head);

  always_comb begin
    hazard = 1'b0;
    sb_any = 1'b0;
    for (int e = 0; e < SB_N; e++) begin
      sb_any = sb_any | sb_q[e].vld;
      for (int k = 0; k < 3; k++) begin
        if (sb_q[e].vld && src.v[k] &&
            sb_q[e].dest == src.r[k])
          hazard = 1'b1;
      end
    end
  end

  assign pop      = !empty && !hazard;
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!empty && !pop && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // ret_q adds the final cycle so retire lands PIPE_LAT after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_instr_q  <= BUBBLE_INSTR;
      issue_real_q   <= 1'b0;
      sb_q           <= '0;
      ret_q          <= '0;
      retire_valid_q <= 1'b0;
      retire_dest_q  <= '0;
      stall_cnt_q    <= '0;
    end else begin
      issue_instr_q  <= pop ? head : BUBBLE_INSTR;
      issue_real_q   <= pop;
      sb_q           <= {sb_q[SB_N-2:0],
                         sb_ent_t'({pop, dest_f(head)})};
      ret_q          <= sb_q[SB_N-1];
      retire_valid_q <= ret_q.vld;
      retire_dest_q  <= ret_q.dest;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign issue_instr  = issue_instr_q;
  assign issue_real   = issue_real_q;
  assign retire_valid = retire_valid_q;
  assign retire_dest  = retire_dest_q;
  assign stall_cnt    = stall_cnt_q;
  assign fifo_level   = 3'(lvl);
  assign busy         = !empty || sb_any;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl: vector table of instruction
// pairs, issue/retire scoreboard, full-FIFO chain and mid-run reset.
module tb_simd_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_instr = '0;
  logic        in_ready;
  logic [11:0] issue_instr;
  logic        issue_real;
  logic        retire_valid;
  logic [3:0]  retire_dest;
  logic [15:0] stall_cnt;
  logic [2:0]  fifo_level;
  logic        busy;

  simd_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .issue_instr  (issue_instr),
    .issue_real   (issue_real),
    .retire_valid (retire_valid),
    .retire_dest  (retire_dest),
    .stall_cnt    (stall_cnt),
    .fifo_level   (fifo_level),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] dest;
  } ret_t;

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    int          gap;
    int          stall;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          max_lvl = 0;
  bit          pend = 0;
  logic        rdy_full;
  logic [11:0] exp_q[$];
  ret_t        ret_q[$];
  int          iss_cyc[$];
  vec_t        vt[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail(string name, logic [31:0] act,
                      logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h",
             name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    ret_t        r;
    cyc++;
    if (rst) begin
      if (pend) begin
        chk("rdy_at_full", rdy_full, issue_real);
        pend = 0;
      end
      if (issue_real) begin
        iss_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail("unexpected_issue", issue_instr, 12'hFFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_instr", issue_instr, e);
          ret_q.push_back('{cyc + 4, {e[7:6], e[5:4]}});
        end
      end else begin
        chk("bubble_word", issue_instr, 12'hFFF);
      end
      if (retire_valid) begin
        if (ret_q.size() == 0) begin
          fail("unexpected_retire", retire_dest, 0);
        end else begin
          r = ret_q.pop_front();
          chk("retire_cycle", cyc, r.cyc);
          chk("retire_dest", retire_dest, r.dest);
        end
      end else if (ret_q.size() != 0 && ret_q[0].cyc < cyc) begin
        r = ret_q.pop_front();
        fail("missed_retire", cyc, r.cyc);
      end
      if (fifo_level == 3'd4) begin
        pend     = 1;
        rdy_full = in_ready;
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
  end

  task automatic push(logic [11:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("push_timeout", n, 0);
    else exp_q.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0 || ret_q.size() != 0)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    int          s0;
    int          g;
    int          n;
    logic [15:0] st;

    vt.push_back('{"indep",    12'h009, 12'h064, 1, 0});
    vt.push_back('{"raw_sub",  12'h009, 12'h134, 4, 3});
    vt.push_back('{"raw_and",  12'h009, 12'h801, 4, 3});
    vt.push_back('{"raw_shl",  12'h009, 12'h410, 4, 3});
    vt.push_back('{"shr_fb",   12'h009, 12'h602, 1, 0});
    vt.push_back('{"waw",      12'h009, 12'h500, 1, 0});
    vt.push_back('{"raw_not",  12'h009, 12'hB10, 4, 3});
    vt.push_back('{"other_bw", 12'h009, 12'h041, 1, 0});
    vt.push_back('{"raw_mac",  12'h009, 12'h30F, 4, 3});
    vt.push_back('{"op12",     12'h009, 12'hC00, 1, 0});

    repeat (2) @(negedge clk);
    chk("rst_issue_instr", issue_instr, 12'hFFF);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_issue_instr", issue_instr, 12'hFFF);
    chk("idle_issue_real", issue_real, 0);
    chk("idle_stall_cnt", stall_cnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_fifo_level", fifo_level, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_retire", retire_valid, 0);

    foreach (vt[i]) begin
      wait_idle();
      s0 = int'(stall_cnt);
      iss_cyc.delete();
      push(vt[i].a);
      push(vt[i].b);
      wait_idle();
      chk({vt[i].name, "_issues"}, iss_cyc.size(), 2);
      g = (iss_cyc.size() >= 2) ? iss_cyc[1] - iss_cyc[0] : -1;
      chk({vt[i].name, "_gap"}, g, vt[i].gap);
      chk({vt[i].name, "_stall"}, int'(stall_cnt) - s0,
          vt[i].stall);
    end

    wait_idle();
    iss_cyc.delete();
    max_lvl = 0;
    for (int i = 0; i < 8; i++) push(12'h300 + 12'(i));
    wait_idle();
    chk("chain_max_level", max_lvl, 4);
    chk("chain_issues", iss_cyc.size(), 8);
    chk("chain_exp_left", exp_q.size(), 0);

    n = 0;
    while (fifo_level != 3'd3 && n < 8) begin
      push(12'h300 + 12'(n));
      n++;
    end
    chk("pre_reset_level", fifo_level, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_issue_instr", issue_instr, 12'hFFF);
    chk("ar_issue_real", issue_real, 0);
    chk("ar_retire_valid", retire_valid, 0);
    chk("ar_retire_dest", retire_dest, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_fifo_level", fifo_level, 0);
    chk("ar_busy", busy, 0);
    exp_q.delete();
    ret_q.delete();
    pend = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    st = stall_cnt;
    chk("post_rst_stall", st, 0);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
